shift_sequencer: RTL



---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 88 ++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake bundle between a producer, the shift sequencer and a consumer.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int AMTW  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMTW-1:0]  in_amt;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle arithmetic/logical right shifter, one bit per cycle,
// with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | ready for a new word
// SHIFT | shifting one bit per cycle, cnt_q shifts remaining
// DONE  | result presented, waiting for downstream accept
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMTW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  sif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q;
  logic [AMTW-1:0]  cnt_q;
  logic             m_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] r_shift_d;

  assign r_shift_d = {(m_q & r_q[WIDTH-1]), r_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      cnt_q       <= '0;
      m_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sif.in_valid && in_ready_q) begin
            r_q        <= sif.in_data;
            cnt_q      <= sif.in_amt;
            m_q        <= sif.in_mode;
            in_ready_q <= 1'b0;
            if (sif.in_amt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_q   <= r_shift_d;
          cnt_q <= cnt_q - 1'b1;
          // cnt_q==1 means this edge performs the last shift
          if (cnt_q == AMTW'(1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (sif.out_ready && out_valid_q) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign sif.in_ready  = in_ready_q;
  assign sif.out_valid = out_valid_q;
  assign sif.out_data  = r_q;
  assign sif.busy      = busy_q;

endmodule
